// File: rtl/wb_regfile_writer.sv
// wb_regfile_writer: MEM/WB write-back queue that shares the register file port with decode,
// forwarding pending values and forcing a write when decode starves the port.
module wb_regfile_writer #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inWbValid,
  input  logic                       inWbRegWrite,
  input  logic                       inWbMemToReg,
  input  logic [DATA_W-1:0]          inWbAluResult,
  input  logic [DATA_W-1:0]          inWbMemData,
  input  logic [ADDR_W-1:0]          inWbWriteReg,
  output logic                       outWbReady,
  input  logic                       inDecodeReadReq,
  input  logic [ADDR_W-1:0]          inDecodeRsReg,
  input  logic [ADDR_W-1:0]          inDecodeRtReg,
  output logic                       outWRInstDecode,
  output logic [ADDR_W-1:0]          outInstDecodeWriteReg,
  output logic [DATA_W-1:0]          outInstDecodeWriteData,
  output logic                       outFwdRsHit,
  output logic [DATA_W-1:0]          outFwdRsData,
  output logic                       outFwdRtHit,
  output logic [DATA_W-1:0]          outFwdRtData,
  output logic                       outDecodeStall,
  output logic [$clog2(DEPTH):0]     outPendingCount
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;

  logic              w_busy, w_forced, w_normal, w_wr, w_push;
  logic [SW-1:0]     w_starve_nxt;
  logic [DATA_W-1:0] w_wb_data;

  assign w_busy     = r_count != '0;
  assign w_forced   = w_busy & inDecodeReadReq & (r_starve == SW'(STARVE_LIMIT));
  assign w_normal   = w_busy & ~inDecodeReadReq;
  assign w_wr       = w_normal | w_forced;
  // Ready depends only on registered count (and reset), never on decode's request.
  assign outWbReady = reset & (r_count < CW'(DEPTH));
  assign w_push     = inWbValid & inWbRegWrite & outWbReady;
  assign w_wb_data  = inWbMemToReg ? inWbMemData : inWbAluResult;

  assign outWRInstDecode        = w_wr;
  assign outDecodeStall         = w_forced;
  assign outInstDecodeWriteReg  = w_wr ? r_addr[r_head] : '0;
  assign outInstDecodeWriteData = w_wr ? r_data[r_head] : '0;
  assign outPendingCount        = r_count;

  assign w_starve_nxt = (w_wr | ~w_busy) ? '0 :
                        (inDecodeReadReq & (r_starve < SW'(STARVE_LIMIT))) ? r_starve + SW'(1) :
                        r_starve;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= inWbWriteReg;
        r_data[r_tail] <= w_wb_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_wr) r_head <= r_head + PW'(1);
      r_count  <= r_count + CW'(w_push) - CW'(w_wr);
      r_starve <= w_starve_nxt;
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    outFwdRsHit  = 1'b0;
    outFwdRsData = '0;
    outFwdRtHit  = 1'b0;
    outFwdRtData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if (r_addr[r_head + PW'(i)] == inDecodeRsReg) begin
          outFwdRsHit  = 1'b1;
          outFwdRsData = r_data[r_head + PW'(i)];
        end
        if (r_addr[r_head + PW'(i)] == inDecodeRtReg) begin
          outFwdRtHit  = 1'b1;
          outFwdRtData = r_data[r_head + PW'(i)];
        end
      end
    end
  end
endmodule
